rns_forward_converter: RTL and testbench
========================================

RNS_FORWARD_CONVERTER -- requirements
Module: rns_forward_converter

Interface
REQ-001 The block SHALL have no parameters; the moduli set SHALL be fixed at n=2, p=0, i.e. {3, 5, 17, 16}, dynamic range M=4080.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  X is presented for conversion.
REQ-005 in_ready  output  1  block can accept X.
REQ-006 X  input  12  binary operand, unsigned.
REQ-007 out_valid  output  1  residues and range_err are valid.
REQ-008 out_ready  input  1  downstream (RNS-to-binary converter / RNS datapath) accepts result.
REQ-009 R1  output  2  X mod 3.
REQ-010 R2  output  3  X mod 5.
REQ-011 R3  output  5  X mod 17.
REQ-012 R4  output  4  X mod 16.
REQ-013 range_err  output  1  captured X >= 4080.

Function
REQ-014 The FSM SHALL have states IDLE, REDUCE, DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, capture X into shift register, clear accumulators, set digit counter to 0, go to REDUCE.
REQ-016 REDUCE: each cycle consume one 2-bit digit d (LSB first, digit i = X[2i+1:2i]) and update all three accumulators; after digit 5 (6 cycles), go to DONE.
REQ-017 acc3 update SHALL be (acc3 + d) mod 3, since 4 ≡ 1 mod 3.
REQ-018 acc5 update SHALL be (acc5 + d) mod 5 for even i and (acc5 - d) mod 5 for odd i, result always in 0..4.
REQ-019 acc17 update SHALL be (acc17 + d*w) mod 17, with w cycling 1,4,16,13 for i mod 4 = 0,1,2,3; result always in 0..16.
REQ-020 R4 SHALL equal the captured X[3:0] and need not pass through the iterative path.
REQ-021 range_err SHALL be set to 1 iff the captured X > 4079; residues SHALL still be the true residues of X.
REQ-022 DONE: out_valid=1, outputs held stable until out_ready=1; on out_valid & out_ready, go to IDLE.
REQ-023 Latency SHALL be 7 cycles: input accepted at edge k, out_valid high from edge k+7.
REQ-024 in_ready SHALL be 0 in REDUCE and DONE; in_valid in those states SHALL be ignored, and X changes SHALL not affect the conversion in flight.
REQ-025 No intermediate accumulator value SHALL exceed its modulus minus 1.
REQ-026 Throughput SHALL be one conversion per at least 8 cycles; there is no bypass from DONE to REDUCE.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear accumulators, counter, R1..R4 and range_err to 0; out_valid=0; in_ready=1 from the first cycle after reset.
REQ-028 rst asserted in REDUCE or DONE SHALL discard the conversion in flight without producing out_valid.
REQ-029 rst and in_valid in the same cycle SHALL accept nothing.

Structure
REQ-030 Package rns_pkg SHALL hold the moduli constants (3, 5, 17, 16), residue widths (2, 3, 5, 4), X width 12, range limit 4080, the acc17 weight table and the FSM state enum.
REQ-031 One sub-module rns_digit_step SHALL hold the combinational per-digit update of acc3/acc5/acc17 from (acc, d, i mod 4); the FSM and registers stay in rns_forward_converter.

Verification
REQ-032 X=100 -> R1=1, R2=0, R3=15, R4=4, range_err=0, out_valid 7 cycles after acceptance.
REQ-033 X=78 -> R1=0, R2=3, R3=10, R4=14, range_err=0.
REQ-034 X=4079 -> R1=2, R2=4, R3=16, R4=15, range_err=0; X=4080 -> R1=R2=R3=R4=0, range_err=1.
REQ-035 X=0 with out_ready held 0 for 5 cycles -> all residues 0; outputs stable and in_ready=0 until out_ready, then IDLE.
REQ-036 rst pulsed on the 3rd REDUCE cycle -> no out_valid; next X=255 -> R1=0, R2=0, R3=0, R4=15.
REQ-037 Random X in 0..4079 fed through rns_forward_converter then the RNS-to-binary converter -> round trip returns X exactly.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared constants and types for the binary-to-RNS forward converter.
// Moduli set {3, 5, 17, 16}, dynamic range 4080.
package rns_pkg;

    localparam int X_W  = 12;
    localparam int MOD1 = 3;
    localparam int MOD2 = 5;
    localparam int MOD3 = 17;
    localparam int MOD4 = 16;
    localparam int R1_W = 2;
    localparam int R2_W = 3;
    localparam int R3_W = 5;
    localparam int R4_W = 4;

    localparam logic [X_W-1:0] RANGE_LIM = 12'd4080;

    // Weight of 2-bit digit i modulo 17 is 4^i, which cycles with period 4.
    localparam logic [3:0][R3_W-1:0] W17_TAB = {5'd13, 5'd16, 5'd4, 5'd1};

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

endpackage

// File: rtl/rns_forward_converter_if.sv
// Handshake bundle between the binary source, the converter and the RNS consumer.
interface rns_forward_converter_if;
    import rns_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [X_W-1:0]    X;
    logic              out_valid;
    logic              out_ready;
    logic [R1_W-1:0]   R1;
    logic [R2_W-1:0]   R2;
    logic [R3_W-1:0]   R3;
    logic [R4_W-1:0]   R4;
    logic              range_err;

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, R1, R2, R3, R4, range_err
    );

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, R1, R2, R3, R4, range_err
    );

endinterface

// File: rtl/rns_digit_step.sv
// Combinational update of the mod-3, mod-5 and mod-17 accumulators by one
// 2-bit digit; every result stays strictly below its modulus.
module rns_digit_step
    import rns_pkg::*;
(
    input  logic [R1_W-1:0] acc3_i,
    input  logic [R2_W-1:0] acc5_i,
    input  logic [R3_W-1:0] acc17_i,
    input  logic [1:0]      d_i,
    input  logic [1:0]      idx_i,
    output logic [R1_W-1:0] acc3_o,
    output logic [R2_W-1:0] acc5_o,
    output logic [R3_W-1:0] acc17_o
);

    logic [2:0] s3, t3;
    logic [3:0] s5, t5;
    logic [6:0] s17, t17;

    always_comb begin
        s3 = {1'b0, acc3_i} + {1'b0, d_i};
        t3 = (s3 >= 3'd3) ? s3 - 3'd3 : s3;

        // 4 = -1 mod 5: odd digits subtract; +5 keeps the sum non-negative.
        if (idx_i[0]) s5 = {1'b0, acc5_i} + 4'd5 - {2'b00, d_i};
        else          s5 = {1'b0, acc5_i} + {2'b00, d_i};
        t5 = (s5 >= 4'd5) ? s5 - 4'd5 : s5;

        s17 = {2'b00, acc17_i} + ({5'd0, d_i} * {2'b00, W17_TAB[idx_i]});
        t17 = s17 % 7'd17;

        acc3_o  = t3[R1_W-1:0];
        acc5_o  = t5[R2_W-1:0];
        acc17_o = t17[R3_W-1:0];
    end

endmodule

// File: rtl/rns_forward_converter.sv
// Iterative binary-to-RNS converter: consumes X two bits per cycle, LSB first,
// and presents {X mod 3, X mod 5, X mod 17, X mod 16} with a valid/ready handshake.
module rns_forward_converter
    import rns_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rns_forward_converter_if.slave bus
);

    state_t            state_q, state_d;
    logic [X_W-1:0]    sh_q, sh_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [R1_W-1:0]   acc3_q, acc3_d, acc3_nx;
    logic [R2_W-1:0]   acc5_q, acc5_d, acc5_nx;
    logic [R3_W-1:0]   acc17_q, acc17_d, acc17_nx;
    logic [R4_W-1:0]   lo_q, lo_d;
    logic              err_q, err_d;
    logic [R1_W-1:0]   r1_q, r1_d;
    logic [R2_W-1:0]   r2_q, r2_d;
    logic [R3_W-1:0]   r3_q, r3_d;
    logic [R4_W-1:0]   r4_q, r4_d;
    logic              rerr_q, rerr_d;

    rns_digit_step u_step (
        .acc3_i  (acc3_q),
        .acc5_i  (acc5_q),
        .acc17_i (acc17_q),
        .d_i     (sh_q[1:0]),
        .idx_i   (cnt_q[1:0]),
        .acc3_o  (acc3_nx),
        .acc5_o  (acc5_nx),
        .acc17_o (acc17_nx)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc3_d  = acc3_q;
        acc5_d  = acc5_q;
        acc17_d = acc17_q;
        lo_d    = lo_q;
        err_d   = err_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        r4_d    = r4_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sh_d    = bus.X;
                    cnt_d   = '0;
                    acc3_d  = '0;
                    acc5_d  = '0;
                    acc17_d = '0;
                    lo_d    = bus.X[R4_W-1:0];
                    err_d   = (bus.X >= RANGE_LIM);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                // Six digit cycles, then one cycle that publishes the result.
                if (cnt_q != 3'd6) begin
                    acc3_d  = acc3_nx;
                    acc5_d  = acc5_nx;
                    acc17_d = acc17_nx;
                    sh_d    = sh_q >> 2;
                    cnt_d   = cnt_q + 3'd1;
                end else begin
                    r1_d    = acc3_q;
                    r2_d    = acc5_q;
                    r3_d    = acc17_q;
                    r4_d    = lo_q;
                    rerr_d  = err_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc3_q  <= '0;
            acc5_q  <= '0;
            acc17_q <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            r4_q    <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc3_q  <= acc3_d;
            acc5_q  <= acc5_d;
            acc17_q <= acc17_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            r4_q    <= r4_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.R1        = r1_q;
    assign bus.R2        = r2_q;
    assign bus.R3        = r3_q;
    assign bus.R4        = r4_q;
    assign bus.range_err = rerr_q;

endmodule

// File: tb/tb_rns_forward_converter.sv
// Scoreboard bench for rns_forward_converter: directed vectors plus a CRT round trip.
module tb_rns_forward_converter;
    import rns_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rns_forward_converter_if bus();

    rns_forward_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int r1, r2, r3, r4, err;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent reconstruction: search the dynamic range for the matching residue tuple.
    function automatic int crt(input int a, input int b, input int c, input int d);
        for (int y = 0; y < 4080; y++)
            if (y % 3 == a && y % 5 == b && y % 17 == c && y % 16 == d) return y;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks the front entry on every valid cycle, pops on handshake.
    bit vld_seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            vld_seen = 1'b0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", int'(bus.out_valid), 0);
            end else begin
                if (!vld_seen) begin
                    vld_seen = 1'b1;
                    chk("latency", cyc - q[0].acc_cyc, 7);
                end
                chk("R1", int'(bus.R1), q[0].r1);
                chk("R2", int'(bus.R2), q[0].r2);
                chk("R3", int'(bus.R3), q[0].r3);
                chk("R4", int'(bus.R4), q[0].r4);
                chk("range_err", int'(bus.range_err), q[0].err);
                chk("in_ready_busy", int'(bus.in_ready), 0);
                if (bus.out_ready) begin
                    if (q[0].x < 4080)
                        chk("roundtrip", crt(int'(bus.R1), int'(bus.R2), int'(bus.R3), int'(bus.R4)), q[0].x);
                    void'(q.pop_front());
                    vld_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input int x, input int r1, input int r2, input int r3, input int r4, input int err);
        exp_t e;
        int   n = 0;
        while (!bus.in_ready && n < 60) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", int'(bus.in_ready), 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.X        = 12'(x);
        e.x = x; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.r4 = r4; e.err = err;
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.X        = 12'($urandom_range(0, 4095));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n;
        int x;
        bus.in_valid  = 1'b1;
        bus.X         = 12'd100;
        bus.out_ready = 1'b1;
        // Reset held with in_valid asserted: nothing may be accepted.
        repeat (3) tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_R1", int'(bus.R1), 0);
        chk("rst_R2", int'(bus.R2), 0);
        chk("rst_R3", int'(bus.R3), 0);
        chk("rst_R4", int'(bus.R4), 0);
        chk("rst_range_err", int'(bus.range_err), 0);

        send(100, 1, 0, 15, 4, 0);
        send(78, 0, 3, 10, 14, 0);
        send(4079, 2, 4, 16, 15, 0);
        send(4080, 0, 0, 0, 0, 1);
        send(4095, 0, 0, 15, 15, 1);
        drain();

        // Downstream stall: result must hold until out_ready.
        bus.out_ready = 1'b0;
        send(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("stall_valid_seen", int'(bus.out_valid), 1);
        repeat (5) tick();
        chk("stall_still_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        tick();
        chk("idle_after_ack", int'(bus.in_ready), 1);
        chk("valid_drop_after_ack", int'(bus.out_valid), 0);
        drain();

        // Reset on the third REDUCE cycle discards the conversion.
        bus.in_valid = 1'b1;
        bus.X        = 12'd1234;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        repeat (10) tick();
        send(255, 0, 0, 0, 15, 0);
        drain();

        // Random round trip through the reference residues and CRT reconstruction.
        for (int i = 0; i < 8; i++) begin
            x = int'($urandom_range(0, 4079));
            send(x, x % 3, x % 5, x % 17, x % 16, 0);
        end
        drain();
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
